// File: rtl/router_grant_sched.sv
// Round-robin, packet-locked grant scheduler for the P/C1/C2 merges of a 3-port tree router node.
// Optional hold-time watchdog is compiled in by defining ROUTER_GRANT_HOLD_WDT_EN.
`timescale 1ns/1ps
module router_grant_sched #(
    parameter int unsigned MAX_HOLD = 64,
    parameter int unsigned CW       = $clog2(MAX_HOLD + 1)
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] P_req,
    input  logic [1:0] C1_req,
    input  logic [1:0] C2_req,
    input  logic       P_tail,
    input  logic       C1_tail,
    input  logic       C2_tail,
    output logic [1:0] P_Grant,
    output logic [1:0] C1_Grant,
    output logic [1:0] C2_Grant,
    output logic [2:0] busy,
    output logic [2:0] hold_err
);
    // State encoding doubles as the registered grant vector.
    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StGrant0 = 2'b01,
        StGrant1 = 2'b10
    } state_e;

    state_e     state_q [3];
    state_e     state_d [3];
    logic [2:0] ptr_q;
    logic [2:0] ptr_d;
    logic [2:0] busy_q;
    logic [2:0] fire;
    logic [1:0] req [3];
    logic [2:0] tail;
    logic       cur;

    assign req[0] = P_req;
    assign req[1] = C1_req;
    assign req[2] = C2_req;
    assign tail   = {C2_tail, C1_tail, P_tail};

    always_comb begin
        cur = 1'b0;
        for (int p = 0; p < 3; p++) begin
            state_d[p] = state_q[p];
            ptr_d[p]   = ptr_q[p];
            cur        = state_q[p][1];
            unique case (state_q[p])
                StIdle: begin
                    if (req[p] == 2'b11) begin
                        state_d[p] = ptr_q[p] ? StGrant1 : StGrant0;
                    end else if (req[p][0]) begin
                        state_d[p] = StGrant0;
                    end else if (req[p][1]) begin
                        state_d[p] = StGrant1;
                    end
                end
                StGrant0, StGrant1: begin
                    if (tail[p] || fire[p]) begin
                        if (req[p][~cur]) begin
                            state_d[p] = cur ? StGrant0 : StGrant1;
                            ptr_d[p]   = cur;
                        end else if (!(req[p][cur] && !fire[p])) begin
                            // A watchdog release never re-grants the offending input directly.
                            state_d[p] = StIdle;
                            ptr_d[p]   = ~cur;
                        end
                    end else if (!req[p][cur]) begin
                        state_d[p] = StIdle;
                        ptr_d[p]   = ~cur;
                    end
                end
                default: state_d[p] = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int p = 0; p < 3; p++) begin
                state_q[p] <= StIdle;
            end
            ptr_q  <= '0;
            busy_q <= '0;
        end else begin
            for (int p = 0; p < 3; p++) begin
                state_q[p] <= state_d[p];
                busy_q[p]  <= (state_d[p] != StIdle);
            end
            ptr_q <= ptr_d;
        end
    end

`ifdef ROUTER_GRANT_HOLD_WDT_EN
    logic [CW-1:0] cnt_q [3];
    logic [CW-1:0] cnt_d [3];
    logic [2:0]    herr_q;

    always_comb begin
        for (int p = 0; p < 3; p++) begin
            fire[p]  = (state_q[p] != StIdle) && (cnt_q[p] == CW'(MAX_HOLD));
            cnt_d[p] = (state_q[p] == StIdle || tail[p] || fire[p]) ? '0 : cnt_q[p] + CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int p = 0; p < 3; p++) begin
                cnt_q[p] <= '0;
            end
            herr_q <= '0;
        end else begin
            for (int p = 0; p < 3; p++) begin
                cnt_q[p] <= cnt_d[p];
            end
            herr_q <= herr_q | fire;
        end
    end

    assign hold_err = herr_q;
`else
    assign fire     = '0;
    assign hold_err = '0;
`endif

    assign P_Grant  = state_q[0];
    assign C1_Grant = state_q[1];
    assign C2_Grant = state_q[2];
    assign busy     = busy_q;

endmodule

// File: tb/tb_router_grant_sched.sv
// Self-checking bench for router_grant_sched: directed steps plus random traffic vs a packet model.
`timescale 1ns/1ps
module tb_router_grant_sched;
    localparam int HOLD = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] p_req = '0, c1_req = '0, c2_req = '0;
    logic       p_tail = 1'b0, c1_tail = 1'b0, c2_tail = 1'b0;
    logic [1:0] p_grant, c1_grant, c2_grant;
    logic [2:0] busy, hold_err;

    int tests = 0;
    int fails = 0;

    // Reference model: owner of each merge (-1 = nobody), preferred input, hold age, error flag.
    int         owner [3];
    int         pref  [3];
    int         age   [3];
    logic [2:0] herr_m;

    router_grant_sched #(.MAX_HOLD(HOLD)) dut (
        .CLK(clk), .RESET(rst),
        .P_req(p_req), .C1_req(c1_req), .C2_req(c2_req),
        .P_tail(p_tail), .C1_tail(c1_tail), .C2_tail(c2_tail),
        .P_Grant(p_grant), .C1_Grant(c1_grant), .C2_Grant(c2_grant),
        .busy(busy), .hold_err(hold_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int p = 0; p < 3; p++) begin
            owner[p] = -1;
            pref[p]  = 0;
            age[p]   = 0;
        end
        herr_m = '0;
    endtask

    task automatic model_port(input int p, input logic [1:0] rq, input logic tl);
        int  i;
        bit  expired;
        if (owner[p] < 0) begin
            if (rq == 2'b11) owner[p] = pref[p];
            else if (rq[0]) owner[p] = 0;
            else if (rq[1]) owner[p] = 1;
            age[p] = 0;
        end else begin
            i = owner[p];
            expired = 1'b0;
`ifdef ROUTER_GRANT_HOLD_WDT_EN
            expired = (age[p] == HOLD);
`endif
            if (tl || expired) begin
                age[p] = 0;
                if (expired) herr_m[p] = 1'b1;
                if (rq[1-i]) begin
                    owner[p] = 1 - i;
                    pref[p]  = i;
                end else if (!rq[i] || expired) begin
                    owner[p] = -1;
                    pref[p]  = 1 - i;
                end
            end else if (!rq[i]) begin
                owner[p] = -1;
                pref[p]  = 1 - i;
                age[p]   = 0;
            end else begin
                age[p] = age[p] + 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s got=%b exp=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [1:0] g [3];
        logic [1:0] e;
        g[0] = p_grant;
        g[1] = c1_grant;
        g[2] = c2_grant;
        for (int p = 0; p < 3; p++) begin
            e = (owner[p] < 0) ? 2'b00 : (owner[p] == 0 ? 2'b01 : 2'b10);
            tests++;
            assert (g[p] === e) else begin
                fails++;
                $error("FAIL grant[%0d] got=%b exp=%b", p, g[p], e);
            end
            tests++;
            assert ($onehot0(g[p])) else begin
                fails++;
                $error("FAIL onehot[%0d] got=%b exp=onehot0", p, g[p]);
            end
            tests++;
            assert (busy[p] === (owner[p] >= 0)) else begin
                fails++;
                $error("FAIL busy[%0d] got=%b exp=%b", p, busy[p], owner[p] >= 0);
            end
        end
        tests++;
        assert (hold_err === herr_m) else begin
            fails++;
            $error("FAIL hold_err got=%b exp=%b", hold_err, herr_m);
        end
    endtask

    // Advance one clock: model consumes the inputs applied before the edge, then compare.
    task automatic cycle();
        logic [1:0] rq [3];
        logic [2:0] tl;
        rq[0] = p_req;
        rq[1] = c1_req;
        rq[2] = c2_req;
        tl    = {c2_tail, c1_tail, p_tail};
        if (rst) model_reset();
        else for (int p = 0; p < 3; p++) model_port(p, rq[p], tl[p]);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic clear_inputs();
        p_req = '0; c1_req = '0; c2_req = '0;
        p_tail = 1'b0; c1_tail = 1'b0; c2_tail = 1'b0;
    endtask

    initial begin
        model_reset();
        // Reset then idle
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        repeat (10) cycle();
        chk("idle_busy", busy, 3'b000);
        chk("idle_grants", {p_grant[0], c1_grant[0], c2_grant[0]}, 3'b000);

        // Single requester on P
        p_req = 2'b01;
        cycle();
        chk("single_grant", {1'b0, p_grant}, 3'b001);
        repeat (4) cycle();
        p_tail = 1'b1;
        p_req  = 2'b00;
        cycle();
        p_tail = 1'b0;
        chk("single_release", {1'b0, p_grant}, 3'b000);

        // Round-robin on C1 with back-to-back packets
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        c1_req = 2'b11;
        for (int k = 0; k < 16; k++) begin
            c1_tail = (k % 4 == 3);
            cycle();
            chk("rr_c1", {1'b0, c1_grant}, (((k + 1) / 4) % 2 == 0) ? 3'b001 : 3'b010);
        end
        clear_inputs();
        cycle();

        // Abort on C2, then pointer prefers input 0
        c2_req = 2'b10;
        cycle();
        chk("abort_grant", {1'b0, c2_grant}, 3'b010);
        cycle();
        c2_req = 2'b00;
        cycle();
        chk("abort_drop", {1'b0, c2_grant}, 3'b000);
        c2_req = 2'b11;
        cycle();
        chk("abort_regrant", {1'b0, c2_grant}, 3'b001);
        clear_inputs();
        cycle();

        // Random traffic on all ports together
        repeat (1500) begin
            rst     = ($urandom_range(0, 299) == 0);
            p_req   = 2'($urandom_range(0, 3));
            c1_req  = 2'($urandom_range(0, 3));
            c2_req  = 2'($urandom_range(0, 3));
            p_tail  = ($urandom_range(0, 3) == 0);
            c1_tail = ($urandom_range(0, 3) == 0);
            c2_tail = ($urandom_range(0, 5) == 0);
            cycle();
        end
        clear_inputs();
        rst = 1'b1;
        cycle();
        rst = 1'b0;

        // Hold watchdog: P requests forever without a tail
        p_req = 2'b01;
        cycle();
        chk("wdt_entry", {1'b0, p_grant}, 3'b001);
        repeat (8) cycle();
        chk("wdt_held8", {1'b0, p_grant}, 3'b001);
        cycle();
`ifdef ROUTER_GRANT_HOLD_WDT_EN
        chk("wdt_release", {1'b0, p_grant}, 3'b000);
        chk("wdt_err", hold_err, 3'b001);
`else
        chk("wdt_noforce", {1'b0, p_grant}, 3'b001);
        chk("wdt_noerr", hold_err, 3'b000);
`endif
        cycle();
        chk("wdt_after", {1'b0, p_grant}, 3'b001);
        repeat (5) cycle();
        p_req = 2'b00;
        rst   = 1'b1;
        cycle();
        rst = 1'b0;
        chk("wdt_reset_err", hold_err, 3'b000);
        chk("wdt_reset_busy", busy, 3'b000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
